// File: rtl/fmul_pipe_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fmul_pipe_if
// Brief    : Operand/result handshake bundle for the pipelined FP multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface fmul_pipe_if #(
    parameter int EW = 8,
    parameter int MW = 23
);
    localparam int c_W = 1 + EW + MW;

    logic [c_W-1:0] x1;
    logic [c_W-1:0] x2;
    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] y;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output x1, x2, in_valid, out_ready,
        input  in_ready, y, out_valid
    );

    modport slave (
        input  x1, x2, in_valid, out_ready,
        output in_ready, y, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/fmul_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fmul_pipe
// Brief    : Pipelined IEEE-style multiplier, RNE rounding, flush-to-zero.
// Revision : 1.0 - initial release
// ============================================================================
module fmul_pipe #(
    parameter int EW     = 8,
    parameter int MW     = 23,
    parameter int STAGES = 3
) (
    input  logic       clk,
    input  logic       rst,
    fmul_pipe_if.slave bus
);
    localparam int            c_W      = 1 + EW + MW;
    localparam int            c_PW     = 2 * (MW + 1);
    localparam logic [EW+1:0] c_BIAS   = (EW+2)'((1 << (EW-1)) - 1);
    localparam logic [EW+1:0] c_EMAX   = (EW+2)'((1 << EW) - 1);
    localparam logic [1:0]    c_K_NORM = 2'd0;
    localparam logic [1:0]    c_K_ZERO = 2'd1;
    localparam logic [1:0]    c_K_INF  = 2'd2;
    localparam logic [1:0]    c_K_NAN  = 2'd3;

    typedef struct packed {
        logic            sign;
        logic [1:0]      kind;
        logic [EW+1:0]   esum;
        logic [c_PW-1:0] prod;
    } mid_t;

    // Special-case class is resolved up front so later stages only carry it.
    function automatic mid_t decode(input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        mid_t          m;
        logic [EW-1:0] ea, eb;
        logic [MW-1:0] ma, mb;
        logic          a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
        ea     = a[c_W-2 -: EW];
        eb     = b[c_W-2 -: EW];
        ma     = a[MW-1:0];
        mb     = b[MW-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (&ea) && (ma == '0);
        b_inf  = (&eb) && (mb == '0);
        a_nan  = (&ea) && (ma != '0);
        b_nan  = (&eb) && (mb != '0);
        m.sign = a[c_W-1] ^ b[c_W-1];
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            m.kind = c_K_NAN;
        else if (a_inf || b_inf)
            m.kind = c_K_INF;
        else if (a_zero || b_zero)
            m.kind = c_K_ZERO;
        else
            m.kind = c_K_NORM;
        m.esum = {2'b00, ea} + {2'b00, eb} - c_BIAS;
        m.prod = c_PW'({1'b1, ma}) * c_PW'({1'b1, mb});
        return m;
    endfunction

    function automatic logic [c_W-1:0] pack(input mid_t m);
        logic            norm, guard, rnd, sticky, up;
        logic [c_PW-2:0] sig;
        logic [MW-1:0]   frac;
        logic [MW:0]     frac_r;
        logic [EW+1:0]   e;
        logic [c_W-1:0]  r;
        norm   = m.prod[c_PW-1];
        sig    = norm ? m.prod[c_PW-2:0] : {m.prod[c_PW-3:0], 1'b0};
        frac   = sig[c_PW-2 -: MW];
        guard  = sig[MW];
        rnd    = sig[MW-1];
        sticky = |sig[MW-2:0];
        up     = guard & (rnd | sticky | frac[0]);
        // A carry out of the fraction leaves it all-zero; only the exponent moves.
        frac_r = {1'b0, frac} + (MW+1)'(up);
        e      = m.esum + (EW+2)'(norm) + (EW+2)'(frac_r[MW]);
        case (m.kind)
            c_K_NAN:  r = {m.sign, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
            c_K_INF:  r = {m.sign, {EW{1'b1}}, {MW{1'b0}}};
            c_K_ZERO: r = {m.sign, {(EW+MW){1'b0}}};
            default: begin
                if (!e[EW+1] && (e >= c_EMAX))
                    r = {m.sign, {EW{1'b1}}, {MW{1'b0}}};
                else if (e[EW+1] || (e == '0))
                    r = {m.sign, {(EW+MW){1'b0}}};
                else
                    r = {m.sign, e[EW-1:0], frac_r[MW-1:0]};
            end
        endcase
        return r;
    endfunction

    logic              w_advance;
    logic [STAGES-1:0] r_vld;
    logic [c_W-1:0]    r_y;
    mid_t              w_front;
    mid_t              w_back;
    logic [c_W-1:0]    w_y_next;

    assign w_advance = !r_vld[STAGES-1] || bus.out_ready;
    assign w_front   = decode(bus.x1, bus.x2);
    assign w_y_next  = pack(w_back);

    generate
        if (STAGES == 1) begin : g_single
            assign w_back = w_front;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_vld <= '0;
                else if (w_advance)
                    r_vld <= bus.in_valid;
            end
        end else begin : g_multi
            // Multiply result is captured at entry; the extra stages only delay it.
            mid_t r_mid [STAGES-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld <= '0;
                    for (int i = 0; i < STAGES-1; i++)
                        r_mid[i] <= '0;
                end else if (w_advance) begin
                    r_vld    <= {r_vld[STAGES-2:0], bus.in_valid};
                    r_mid[0] <= w_front;
                    for (int i = 1; i < STAGES-1; i++)
                        r_mid[i] <= r_mid[i-1];
                end
            end

            assign w_back = r_mid[STAGES-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_y <= '0;
        else if (w_advance)
            r_y <= w_y_next;
    end

    assign bus.y         = r_y;
    assign bus.out_valid = r_vld[STAGES-1];
    assign bus.in_ready  = w_advance;
endmodule
`default_nettype wire

// File: tb/tb_fmul_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fmul_pipe
// Brief    : Directed and reference-model bench for fmul_pipe (STAGES 3/1/4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmul_pipe;
    localparam int c_N = 40;

    logic clk;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    fmul_pipe_if #(.EW(8), .MW(23)) b3 ();
    fmul_pipe_if #(.EW(8), .MW(23)) b1 ();
    fmul_pipe_if #(.EW(8), .MW(23)) b4 ();

    fmul_pipe #(.EW(8), .MW(23), .STAGES(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
    fmul_pipe #(.EW(8), .MW(23), .STAGES(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    fmul_pipe #(.EW(8), .MW(23), .STAGES(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Independent RNE/FTZ model for normal operands: remainder-vs-half rounding.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint unsigned p, q, rem, half;
        int              sh, e;
        logic            s;
        s    = a[31] ^ b[31];
        p    = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        sh   = p[47] ? 24 : 23;
        e    = int'(a[30:23]) + int'(b[30:23]) - 127 + (sh - 23);
        q    = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (q[24]) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, e[7:0], q[22:0]};
    endfunction

    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        b3.x1 = a;
        b3.x2 = b;
        b3.in_valid  = 1'b1;
        b3.out_ready = 1'b1;
        step();
        b3.in_valid = 1'b0;
        check({tag, "_ov1"}, 32'(b3.out_valid), 32'd0);
        step();
        check({tag, "_ov2"}, 32'(b3.out_valid), 32'd0);
        step();
        check({tag, "_ov3"}, 32'(b3.out_valid), 32'd1);
        check({tag, "_y"}, b3.y, exp);
        step();
    endtask

    logic [31:0] bp_x   [8];
    logic [31:0] bp_exp [8];
    logic [31:0] sa     [c_N];
    logic [31:0] sb     [c_N];
    logic [31:0] held;
    int          sent, rcv, i1, i4;

    initial begin
        rst = 1'b1;
        b3.x1 = '0; b3.x2 = '0; b3.in_valid = 1'b0; b3.out_ready = 1'b1;
        b1.x1 = '0; b1.x2 = '0; b1.in_valid = 1'b0; b1.out_ready = 1'b1;
        b4.x1 = '0; b4.x2 = '0; b4.in_valid = 1'b0; b4.out_ready = 1'b1;
        #3;
        check("rst_ov",    32'(b3.out_valid), 32'd0);
        check("rst_y",     b3.y, 32'd0);
        check("rst_ready", 32'(b3.in_ready), 32'd1);
        check("rst_ov1",   32'(b1.out_valid), 32'd0);
        check("rst_ov4",   32'(b4.out_valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_one("lat",     32'h3FC00000, 32'h40000000, 32'h40400000);
        run_one("tie_even",32'h3F800800, 32'h3F800800, 32'h3F801000);
        run_one("lsb",     32'h3F800001, 32'h3F800001, 32'h3F800002);
        run_one("ovf",     32'h7F000000, 32'h40000000, 32'h7F800000);
        run_one("inf_zero",32'h7F800000, 32'h80000000, 32'hFFC00000);
        run_one("unf",     32'h00800000, 32'h00800000, 32'h00000000);
        run_one("nan",     32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        run_one("inf_neg", 32'hFF800000, 32'h40000000, 32'hFF800000);

        // Backpressure: x*2.0 only bumps the exponent, so expectations are exact.
        for (int i = 0; i < 8; i++) begin
            bp_x[i]   = 32'h3F800000 + 32'(i) * 32'h00100000;
            bp_exp[i] = bp_x[i] + 32'h00800000;
        end
        sent = 0;
        rcv  = 0;
        held = '0;
        for (int c = 0; c < 20; c++) begin
            b3.out_ready = !(c >= 5 && c < 8);
            #1;
            if (c >= 5 && c < 8) begin
                check($sformatf("bp_ready_c%0d", c), 32'(b3.in_ready), 32'd0);
                check($sformatf("bp_ov_c%0d", c), 32'(b3.out_valid), 32'd1);
                if (c == 5) held = b3.y;
                else check($sformatf("bp_hold_c%0d", c), b3.y, held);
            end
            if (b3.out_valid && b3.out_ready) begin
                if (rcv < 8) check($sformatf("bp_y%0d", rcv), b3.y, bp_exp[rcv]);
                rcv++;
            end
            if (sent < 8) begin
                b3.x1 = bp_x[sent];
                b3.x2 = 32'h40000000;
                b3.in_valid = 1'b1;
                if (b3.in_ready) sent++;
            end else begin
                b3.in_valid = 1'b0;
            end
            step();
        end
        b3.out_ready = 1'b1;
        check("bp_count", 32'(rcv), 32'd8);

        // Reset with two results in flight.
        b3.x1 = 32'h3F800000; b3.x2 = 32'h40000000; b3.in_valid = 1'b1;
        step();
        b3.x1 = 32'h40000000; b3.x2 = 32'h40000000;
        step();
        b3.in_valid = 1'b0;
        step();
        check("mid_ov_pre", 32'(b3.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_ov",    32'(b3.out_valid), 32'd0);
        check("mid_y",     b3.y, 32'd0);
        check("mid_ready", 32'(b3.in_ready), 32'd1);
        step();
        rst = 1'b0;
        check("post_ov", 32'(b3.out_valid), 32'd0);
        run_one("post", 32'h3FC00000, 32'h40000000, 32'h40400000);

        // STAGES=1 and STAGES=4 against the reference model.
        for (int i = 0; i < c_N; i++) begin
            sa[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(40, 214)), 23'($urandom)};
            sb[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(40, 214)), 23'($urandom)};
        end
        i1 = 0;
        i4 = 0;
        for (int c = 0; c < c_N + 8; c++) begin
            if (b1.out_valid) begin
                if (i1 < c_N) check($sformatf("s1_y%0d", i1), b1.y, ref_mul(sa[i1], sb[i1]));
                i1++;
            end
            if (b4.out_valid) begin
                if (i4 < c_N) check($sformatf("s4_y%0d", i4), b4.y, ref_mul(sa[i4], sb[i4]));
                i4++;
            end
            if (c < c_N) begin
                b1.x1 = sa[c]; b1.x2 = sb[c]; b1.in_valid = 1'b1;
                b4.x1 = sa[c]; b4.x2 = sb[c]; b4.in_valid = 1'b1;
            end else begin
                b1.in_valid = 1'b0;
                b4.in_valid = 1'b0;
            end
            step();
        end
        check("s1_count", 32'(i1), 32'(c_N));
        check("s4_count", 32'(i4), 32'(c_N));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fmul_pipe.md
FMUL_PIPE -- requirements
Module: fmul_pipe

Interface
REQ-001 Parameter EW, default 8: exponent field width in bits.
REQ-002 Parameter MW, default 23: stored mantissa field width in bits; word width W = 1+EW+MW.
REQ-003 Parameter STAGES, default 3, legal 1..4: pipeline depth in cycles.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 x1  input  W  operand A, IEEE-style {sign, exp, mantissa}.
REQ-007 x2  input  W  operand B.
REQ-008 in_valid  input  1  operands present this cycle.
REQ-009 in_ready  output  1  block accepts operands this cycle.
REQ-010 y  output  W  product.
REQ-011 out_valid  output  1  y holds a result.
REQ-012 out_ready  input  1  consumer takes y this cycle.

Function
REQ-013 Block SHALL issue a transfer when in_valid && in_ready, and complete one when out_valid && out_ready.
REQ-014 Global advance = !out_valid || out_ready; in_ready SHALL equal advance; every stage register, including valid bits, SHALL load only when advance is 1.
REQ-015 An accepted operand pair SHALL appear at y with out_valid=1 exactly STAGES cycles after acceptance when advance stays 1; stall cycles add one-for-one.
REQ-016 Throughput SHALL be one result per cycle; results SHALL leave in acceptance order, none dropped or duplicated.
REQ-017 Bubbles SHALL not collapse; an empty stage advances only with the global advance.
REQ-018 y and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 Sign of every result, including zero, inf and NaN, SHALL be x1 sign XOR x2 sign.
REQ-020 Zero or subnormal input (exp=0) SHALL be treated as signed zero.
REQ-021 Either input NaN (exp all ones, mantissa nonzero), or inf times zero, SHALL give exp all ones with mantissa MSB=1 and other mantissa bits 0.
REQ-022 Otherwise, inf times finite-or-inf SHALL give signed inf (exp all ones, mantissa 0).
REQ-023 Otherwise, zero times finite SHALL give signed zero.
REQ-024 For finite normal inputs, the product of {1,m1} and {1,m2} SHALL be computed exactly as a 2*(MW+1)-bit value, then normalised.
REQ-025 The normalised value SHALL be rounded to nearest, ties to even, using guard, round and sticky bits.
REQ-026 Rounding carry-out SHALL renormalise the result and increment the exponent.
REQ-027 Biased exponent SHALL be e1+e2-bias+norm+roundcarry, where bias = 2^(EW-1)-1, computed at width EW+2 signed.
REQ-028 A biased exponent of all ones or greater SHALL give signed inf (overflow).
REQ-029 A biased exponent of 0 or less SHALL give signed zero (flush-to-zero, no subnormal output).
REQ-030 Special-case flags SHALL be decoded in stage 1 and carried with the data, so the result is independent of STAGES.
REQ-031 When STAGES=1, the multiply, round and pack SHALL complete within the single stage.
REQ-032 When STAGES>1, the multiply SHALL occupy the early stages and the round/pack the final stage.

Reset
REQ-033 While rst=1, all stage valid bits and out_valid SHALL be 0 and y SHALL be 0, asynchronously.
REQ-034 While rst=1, in_ready SHALL be 1.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight results; none SHALL appear after rst deasserts.
REQ-036 The first transfer after reset SHALL be accepted on the first rising edge with rst=0.

Verification
REQ-037 Basic latency (defaults, out_ready=1): accept 0x3FC00000 * 0x40000000 -> y=0x40400000 with out_valid exactly 3 cycles later.
REQ-038 Rounding tie: 0x3F800800 * 0x3F800800 -> 0x3F801000 (tie, even kept); 0x3F800001 * 0x3F800001 -> 0x3F800002.
REQ-039 Special values: 0x7F000000 * 0x40000000 -> 0x7F800000; 0x7F800000 * 0x80000000 -> 0xFFC00000; 0x00800000 * 0x00800000 -> 0x00000000; 0x7FC00001 * 0x3F800000 -> 0x7FC00000.
REQ-040 Backpressure: stream 8 pairs back-to-back, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 and y stable during the stall, all 8 results in order, no loss.
REQ-041 Reset mid-flight: assert rst with 2 results in flight -> out_valid=0 immediately, no stale result after release, next pair emerges after STAGES cycles.
REQ-042 Parameter sweep: STAGES=1 and 4 with random normal pairs -> bit-exact against a round-to-nearest-even, flush-to-zero reference model.
